pipeline_hazard_ctrl: RTL and testbench

Stall/flush sequencer for the 5-stage pipeline. It sits beside the forwarding unit and handles the hazards forwarding cannot resolve:
- load-use dependencies, which need a one-cycle bubble;
- taken branches resolved in EX, which flush IF/ID and ID/EX;
- multi-cycle data-memory accesses, which freeze the whole pipeline until `dmem_ready`.

A watchdog halts the pipeline if memory never answers. Saturating counters report stall and flush activity.

---
 rtl/pipeline_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with memory watchdog and activity counters
module pipeline_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] IF_IDregRS,
    input  logic [REG_W-1:0] IF_IDregRT,
    input  logic             IF_IDuses_rt,
    input  logic             ID_EXmemread,
    input  logic [REG_W-1:0] ID_EXregRT,
    input  logic             EX_branch_taken,
    input  logic             EX_MEMmemop,
    input  logic             dmem_ready,
    output logic             PCwrite,
    output logic             IF_IDwrite,
    output logic             IF_IDflush,
    output logic             ID_EXwrite,
    output logic             ID_EXflush,
    output logic             EX_MEMwrite,
    output logic             MEM_WBbubble,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [WC_W-1:0] wait_cnt, wait_cnt_next;
    logic            freeze;
    logic            loaduse;

    // Hazard detection terms; freeze only matters outside HALT, which has top priority anyway
    always_comb begin
        freeze  = EX_MEMmemop && !dmem_ready;
        loaduse = ID_EXmemread && (ID_EXregRT != '0) &&
                  ((ID_EXregRT == IF_IDregRS) ||
                   (IF_IDuses_rt && (ID_EXregRT == IF_IDregRT)));
    end

    // State and frozen-cycle counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state logic and prioritised pipeline controls (HALT > freeze > branch > load-use)
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        PCwrite       = 1'b1;
        IF_IDwrite    = 1'b1;
        IF_IDflush    = 1'b0;
        ID_EXwrite    = 1'b1;
        ID_EXflush    = 1'b0;
        EX_MEMwrite   = 1'b1;
        MEM_WBbubble  = 1'b0;
        halt          = 1'b0;

        case (state)
            RUN: begin
                if (freeze) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!freeze) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = HALT;
                end else begin
                    wait_cnt_next = wait_cnt + WC_W'(1);
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase

        if (reset) begin
            PCwrite     = 1'b0;
            IF_IDwrite  = 1'b0;
            ID_EXwrite  = 1'b0;
            EX_MEMwrite = 1'b0;
        end else if (state == HALT || freeze) begin
            // Frozen pipeline: hold every stage, drain a bubble into WB
            PCwrite      = 1'b0;
            IF_IDwrite   = 1'b0;
            ID_EXwrite   = 1'b0;
            EX_MEMwrite  = 1'b0;
            MEM_WBbubble = 1'b1;
            halt         = (state == HALT);
        end else if (EX_branch_taken) begin
            // Younger instructions are squashed, so a coincident load-use is moot
            IF_IDflush = 1'b1;
            ID_EXflush = 1'b1;
        end else if (loaduse) begin
            PCwrite    = 1'b0;
            IF_IDwrite = 1'b0;
            ID_EXflush = 1'b1;
        end
    end

    // Saturating activity counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!PCwrite && state != HALT && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (IF_IDflush && flush_count != '1) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int REG_W   = 5;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Output vector order: PCwrite IF_IDwrite IF_IDflush ID_EXwrite ID_EXflush EX_MEMwrite MEM_WBbubble halt
    localparam logic [7:0] O_NORM = 8'b1101_0100;
    localparam logic [7:0] O_BR   = 8'b1111_1100;
    localparam logic [7:0] O_LU   = 8'b0001_1100;
    localparam logic [7:0] O_FRZ  = 8'b0000_0010;
    localparam logic [7:0] O_HLT  = 8'b0000_0011;
    localparam logic [7:0] O_RST  = 8'b0000_0000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [REG_W-1:0] IF_IDregRS = '0;
    logic [REG_W-1:0] IF_IDregRT = '0;
    logic             IF_IDuses_rt = 1'b0;
    logic             ID_EXmemread = 1'b0;
    logic [REG_W-1:0] ID_EXregRT = '0;
    logic             EX_branch_taken = 1'b0;
    logic             EX_MEMmemop = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             PCwrite, IF_IDwrite, IF_IDflush, ID_EXwrite, ID_EXflush;
    logic             EX_MEMwrite, MEM_WBbubble, halt;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [7:0]       outv;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .IF_IDregRS(IF_IDregRS), .IF_IDregRT(IF_IDregRT), .IF_IDuses_rt(IF_IDuses_rt),
        .ID_EXmemread(ID_EXmemread), .ID_EXregRT(ID_EXregRT),
        .EX_branch_taken(EX_branch_taken), .EX_MEMmemop(EX_MEMmemop), .dmem_ready(dmem_ready),
        .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite), .IF_IDflush(IF_IDflush),
        .ID_EXwrite(ID_EXwrite), .ID_EXflush(ID_EXflush), .EX_MEMwrite(EX_MEMwrite),
        .MEM_WBbubble(MEM_WBbubble), .halt(halt),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign outv = {PCwrite, IF_IDwrite, IF_IDflush, ID_EXwrite, ID_EXflush,
                   EX_MEMwrite, MEM_WBbubble, halt};

    typedef struct {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses;
        logic             mr;
        logic [REG_W-1:0] exrt;
        logic             br;
        logic             mo;
        logic             rdy;
        logic [7:0]       exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt, input logic uses,
                         input logic mr, input logic [REG_W-1:0] exrt, input logic br,
                         input logic mo, input logic rdy);
        IF_IDregRS      = rs;
        IF_IDregRT      = rt;
        IF_IDuses_rt    = uses;
        ID_EXmemread    = mr;
        ID_EXregRT      = exrt;
        EX_branch_taken = br;
        EX_MEMmemop     = mo;
        dmem_ready      = rdy;
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, check the combinational outputs mid-cycle, then advance one cycle
    task automatic cyc(input string nm, input logic br, input logic mo, input logic rdy,
                       input logic mr, input logic [7:0] exp);
        drive(5'd5, 5'd0, 1'b0, mr, 5'd5, br, mo, rdy);
        #3;
        chk(nm, 32'(outv), 32'(exp));
        tick();
    endtask

    // Asynchronous reset pulse placed mid-cycle, with busy inputs to show they are overridden
    task automatic do_reset(input string nm);
        @(posedge clk);
        #3;
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk({nm, "_outs"}, 32'(outv), 32'(O_RST));
        chk({nm, "_stall"}, 32'(stall_cycles), 32'd0);
        chk({nm, "_flush"}, 32'(flush_count), 32'd0);
        #3;
        reset = 1'b0;
        drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    function automatic logic [7:0] expect_out(input logic halted, input logic [REG_W-1:0] rs,
                                              input logic [REG_W-1:0] rt, input logic uses,
                                              input logic mr, input logic [REG_W-1:0] exrt,
                                              input logic br, input logic mo, input logic rdy);
        logic lu;
        lu = mr && (exrt != 0) && (exrt == rs || (uses && exrt == rt));
        if (halted)         return O_HLT;
        if (mo && !rdy)     return O_FRZ;
        if (br)             return O_BR;
        if (lu)             return O_LU;
        return O_NORM;
    endfunction

    initial begin
        // rs rt uses mr exrt br mo rdy exp
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[3]  = '{5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[4]  = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[5]  = '{5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[7]  = '{5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FRZ};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_NORM};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_NORM};
        vecs[11] = '{5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, O_FRZ};
        vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, O_BR};
    end

    // Random reference model state: consecutive frozen cycles and sticky halt
    logic m_halt;
    int   m_len, m_stall, m_flush;

    initial begin
        logic [7:0] e;
        logic       r_mo, r_rdy, r_br, r_mr, r_uses;
        logic [REG_W-1:0] r_rs, r_rt, r_exrt;

        // Reset state
        reset = 1'b1;
        #2;
        chk("reset_outs", 32'(outv), 32'(O_RST));
        chk("reset_stall", 32'(stall_cycles), 32'd0);
        chk("reset_flush", 32'(flush_count), 32'd0);
        tick();
        #2;
        reset = 1'b0;
        tick();

        // Table-driven single-cycle decisions
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].uses, vecs[i].mr, vecs[i].exrt,
                  vecs[i].br, vecs[i].mo, vecs[i].rdy);
            #3;
            chk($sformatf("vec[%0d]", i), 32'(outv), 32'(vecs[i].exp));
            tick();
        end
        chk("vec_stall", 32'(stall_cycles), 32'd5);
        chk("vec_flush", 32'(flush_count), 32'd3);

        // Load-use: one bubble, stall counted once
        do_reset("rst_lu");
        cyc("lu_bubble", 1'b0, 1'b0, 1'b0, 1'b1, O_LU);
        cyc("lu_after", 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);
        chk("lu_stall", 32'(stall_cycles), 32'd1);

        // Branch overrides a simultaneous load-use
        do_reset("rst_br");
        cyc("br_over_lu", 1'b1, 1'b0, 1'b0, 1'b1, O_BR);
        chk("br_flush", 32'(flush_count), 32'd1);
        chk("br_stall", 32'(stall_cycles), 32'd0);

        // Memory wait: three frozen cycles, ready cycle advances
        do_reset("rst_mw");
        for (int i = 0; i < 3; i++) cyc($sformatf("mw_frz%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ);
        cyc("mw_ready", 1'b0, 1'b1, 1'b1, 1'b0, O_NORM);
        chk("mw_stall", 32'(stall_cycles), 32'd3);
        // Back in RUN: a fresh freeze must last a full TIMEOUT before halting
        for (int i = 0; i < TIMEOUT; i++) cyc($sformatf("mw_refrz%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ);
        cyc("mw_rehalt", 1'b0, 1'b1, 1'b0, 1'b0, O_HLT);

        // Branch held during a freeze is applied once unfrozen
        do_reset("rst_bf");
        cyc("bf_frz0", 1'b1, 1'b1, 1'b0, 1'b0, O_FRZ);
        cyc("bf_frz1", 1'b1, 1'b1, 1'b0, 1'b0, O_FRZ);
        chk("bf_noflush", 32'(flush_count), 32'd0);
        cyc("bf_flush", 1'b1, 1'b1, 1'b1, 1'b0, O_BR);
        chk("bf_flush_cnt", 32'(flush_count), 32'd1);

        // Timeout: frozen cycles 0..TIMEOUT-1, halt from cycle TIMEOUT onward
        do_reset("rst_to");
        for (int i = 0; i < TIMEOUT; i++) cyc($sformatf("to_frz%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ);
        for (int i = 0; i < 3; i++) cyc($sformatf("to_halt%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, O_HLT);
        chk("to_stall", 32'(stall_cycles), 32'(TIMEOUT));
        do_reset("rst_halt");
        cyc("to_run", 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);

        // Reset mid-wait clears the frozen-cycle count
        for (int i = 0; i < TIMEOUT - 1; i++) cyc($sformatf("mid_frz%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ);
        do_reset("rst_mid");
        for (int i = 0; i < TIMEOUT; i++) cyc($sformatf("mid_refrz%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ);
        cyc("mid_halt", 1'b0, 1'b1, 1'b0, 1'b0, O_HLT);

        // Saturation of the stall counter
        do_reset("rst_sat");
        for (int i = 0; i < 10; i++) cyc($sformatf("sat_lu%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, O_LU);
        chk("sat_stall", 32'(stall_cycles), 32'(CNT_MAX));
        for (int i = 0; i < 10; i++) cyc($sformatf("sat_br%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, O_BR);
        chk("sat_flush", 32'(flush_count), 32'(CNT_MAX));

        // Randomised run against the reference model
        do_reset("rst_rnd");
        m_halt = 1'b0; m_len = 0; m_stall = 0; m_flush = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(63) == 0) begin
                do_reset("rnd_rst");
                m_halt = 1'b0; m_len = 0; m_stall = 0; m_flush = 0;
            end
            r_rs   = REG_W'($urandom_range(3));
            r_rt   = REG_W'($urandom_range(3));
            r_exrt = REG_W'($urandom_range(3));
            r_uses = 1'($urandom_range(1));
            r_mr   = 1'($urandom_range(1));
            r_br   = ($urandom_range(3) == 0);
            r_mo   = 1'($urandom_range(1));
            r_rdy  = 1'($urandom_range(1));
            drive(r_rs, r_rt, r_uses, r_mr, r_exrt, r_br, r_mo, r_rdy);
            #3;
            e = expect_out(m_halt, r_rs, r_rt, r_uses, r_mr, r_exrt, r_br, r_mo, r_rdy);
            chk("rnd_out", 32'(outv), 32'(e));
            if (!m_halt) begin
                if (!e[7] && m_stall < CNT_MAX) m_stall++;
                if (r_mo && !r_rdy) begin
                    m_len++;
                    if (m_len == TIMEOUT) m_halt = 1'b1;
                end else begin
                    m_len = 0;
                end
            end
            if (e[5] && m_flush < CNT_MAX) m_flush++;
            tick();
            chk("rnd_stall", 32'(stall_cycles), 32'(m_stall));
            chk("rnd_flush", 32'(flush_count), 32'(m_flush));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
